// File: rtl/cpu_bus_ram_responder_pkg.sv
// Shared types for the CPU bus RAM responder: FSM states, port identifiers,
// the latched transaction record and the round-robin port selection helper.
package cpu_bus_ram_responder_pkg;

   // Widest word index the transaction record can carry (30 bits of a 32-bit byte address)
   localparam int INDEX_W = 30;
   // Wait-state counter width, enough for 0..15
   localparam int WAIT_W  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } responder_state_t;

   typedef enum logic {
      IBUS = 1'b0,
      DBUS = 1'b1
   } bus_port_t;

   typedef struct packed {
      bus_port_t            port;
      logic                 rw;
      logic [INDEX_W-1:0]   index;
      logic [31:0]          wdata;
   } bus_txn_t;

   // Round-robin choice: a lone requester wins; on a tie the port not granted last time wins.
   function automatic bus_port_t pick_port(input logic ibus_req, input logic dbus_req,
                                           input bus_port_t last_grant);
      bus_port_t result;
      if (ibus_req && dbus_req) begin
         result = (last_grant == DBUS) ? IBUS : DBUS;
      end else if (ibus_req) begin
         result = IBUS;
      end else begin
         result = DBUS;
      end
      return result;
   endfunction

endpackage

// File: rtl/cpu_bus_ram_responder_bram_single_port.sv
// Single-port block RAM: one enable, one write enable, registered read data.
// Read-first on a write cycle; contents are never reset.
module bram_single_port #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
   logic [WIDTH-1:0] rdata_reg;

   // Enabled access: optional write plus a registered read of the same word
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata_reg <= mem[addr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/cpu_bus_ram_responder.sv
// Responder for the CPU instruction and data buses, sharing one single-port RAM.
// Round-robin arbitration, one transaction at a time, programmable wait states.
// Each completion is a one-cycle ready pulse; read data is held per port
// until that port's next read completes.
module cpu_bus_ram_responder
   import cpu_bus_ram_responder_pkg::*;
#(
   parameter int SIZE        = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_ibus_request,
   output logic        o_ibus_ready,
   input  logic [31:0] i_ibus_address,
   output logic [31:0] o_ibus_rdata,
   input  logic        i_dbus_rw,
   input  logic        i_dbus_request,
   output logic        o_dbus_ready,
   input  logic [31:0] i_dbus_address,
   output logic [31:0] o_dbus_rdata,
   input  logic [31:0] i_dbus_wdata
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

   responder_state_t     state_reg, state_next;
   bus_txn_t             txn_reg, txn_next;
   bus_port_t            last_grant_reg, last_grant_next;
   logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
   logic                 ibus_ready_reg, dbus_ready_reg;
   logic [31:0]          ibus_rdata_reg, dbus_rdata_reg;

   bus_port_t            grant;
   logic [INDEX_W-1:0]   ibus_index, dbus_index;
   logic                 ram_en, ram_we;
   logic [SIZE-1:0]      ram_addr;
   logic [31:0]          ram_rdata;
   logic                 ibus_responding, dbus_read_responding;
   logic                 unused_addr_bits;

   // Word index ignores the byte offset and everything above the RAM depth, so addresses alias
   assign ibus_index = INDEX_W'(i_ibus_address[SIZE+1:2]);
   assign dbus_index = INDEX_W'(i_dbus_address[SIZE+1:2]);
   assign unused_addr_bits = ^{i_ibus_address[1:0], i_ibus_address[31:SIZE+2],
                               i_dbus_address[1:0], i_dbus_address[31:SIZE+2],
                               txn_reg.index[INDEX_W-1:SIZE]};

   assign grant = pick_port(i_ibus_request, i_dbus_request, last_grant_reg);

   // State, transaction latch, arbitration history and wait counter
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_reg      <= IDLE;
         txn_reg        <= '0;
         last_grant_reg <= DBUS;
         wait_cnt_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         txn_reg        <= txn_next;
         last_grant_reg <= last_grant_next;
         wait_cnt_reg   <= wait_cnt_next;
      end
   end

   // Next-state logic: grant in IDLE, one RAM cycle in ACCESS, count in WAIT, pulse in RESPOND
   always_comb begin
      state_next      = state_reg;
      txn_next        = txn_reg;
      last_grant_next = last_grant_reg;
      wait_cnt_next   = wait_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (i_ibus_request || i_dbus_request) begin
               state_next      = ACCESS;
               last_grant_next = grant;
               txn_next.port   = grant;
               if (grant == DBUS) begin
                  txn_next.rw    = i_dbus_rw;
                  txn_next.index = dbus_index;
                  txn_next.wdata = i_dbus_wdata;
               end else begin
                  txn_next.rw    = 1'b0;
                  txn_next.index = ibus_index;
                  txn_next.wdata = '0;
               end
            end
         end
         ACCESS: begin
            if (WAIT_STATES == 0) begin
               state_next = RESPOND;
            end else begin
               wait_cnt_next = WAIT_LOAD;
               state_next    = WAIT;
            end
         end
         WAIT: begin
            wait_cnt_next = wait_cnt_reg - 1'b1;
            if (wait_cnt_reg == WAIT_W'(1)) begin
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            // Requests are still held high this cycle by the initiator, so they are not sampled
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // RAM is enabled only during ACCESS; its output then stays put through WAIT and RESPOND
   assign ram_en   = (state_reg == ACCESS);
   assign ram_we   = ram_en && txn_reg.rw;
   assign ram_addr = txn_reg.index[SIZE-1:0];

   bram_single_port #(
      .WIDTH      (32),
      .DEPTH_LOG2 (SIZE)
   ) u_ram (
      .clk   (i_clock),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (txn_reg.wdata),
      .rdata (ram_rdata)
   );

   assign ibus_responding      = (state_reg == RESPOND) && (txn_reg.port == IBUS);
   assign dbus_read_responding = (state_reg == RESPOND) && (txn_reg.port == DBUS) && !txn_reg.rw;

   // Ready pulses coincide with RESPOND; read data is captured there and held afterwards
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         ibus_ready_reg <= 1'b0;
         dbus_ready_reg <= 1'b0;
         ibus_rdata_reg <= '0;
         dbus_rdata_reg <= '0;
      end else begin
         ibus_ready_reg <= (state_next == RESPOND) && (txn_reg.port == IBUS);
         dbus_ready_reg <= (state_next == RESPOND) && (txn_reg.port == DBUS);
         if (ibus_responding) begin
            ibus_rdata_reg <= ram_rdata;
         end
         if (dbus_read_responding) begin
            dbus_rdata_reg <= ram_rdata;
         end
      end
   end

   // During the ready cycle the RAM output is forwarded so data is valid together with ready
   assign o_ibus_ready = ibus_ready_reg;
   assign o_dbus_ready = dbus_ready_reg;
   assign o_ibus_rdata = ibus_responding      ? ram_rdata : ibus_rdata_reg;
   assign o_dbus_rdata = dbus_read_responding ? ram_rdata : dbus_rdata_reg;

endmodule

// File: tb/tb_cpu_bus_ram_responder.sv
// Bench for cpu_bus_ram_responder: two instances (WAIT_STATES 0 and 3, SIZE 12)
// checked against a word-level memory model with latency and arbitration rules.
module tb_cpu_bus_ram_responder;

   localparam int PI = 0;
   localparam int PD = 1;

   logic        clk = 1'b0;
   logic        rst    [2];
   logic        ireq   [2];
   logic        dreq   [2];
   logic        drw    [2];
   logic [31:0] iaddr  [2];
   logic [31:0] daddr  [2];
   logic [31:0] dwdata [2];
   logic        iready [2];
   logic        dready [2];
   logic [31:0] irdata [2];
   logic [31:0] drdata [2];

   always #5 clk = ~clk;

   cpu_bus_ram_responder #(.SIZE(12), .WAIT_STATES(0)) dut0 (
      .i_clock(clk), .i_reset(rst[0]),
      .i_ibus_request(ireq[0]), .o_ibus_ready(iready[0]),
      .i_ibus_address(iaddr[0]), .o_ibus_rdata(irdata[0]),
      .i_dbus_rw(drw[0]), .i_dbus_request(dreq[0]), .o_dbus_ready(dready[0]),
      .i_dbus_address(daddr[0]), .o_dbus_rdata(drdata[0]), .i_dbus_wdata(dwdata[0])
   );

   cpu_bus_ram_responder #(.SIZE(12), .WAIT_STATES(3)) dut3 (
      .i_clock(clk), .i_reset(rst[1]),
      .i_ibus_request(ireq[1]), .o_ibus_ready(iready[1]),
      .i_ibus_address(iaddr[1]), .o_ibus_rdata(irdata[1]),
      .i_dbus_rw(drw[1]), .i_dbus_request(dreq[1]), .o_dbus_ready(dready[1]),
      .i_dbus_address(daddr[1]), .o_dbus_rdata(drdata[1]), .i_dbus_wdata(dwdata[1])
   );

   // Reference model: memory by (instance, word index), held rdata per port, last granted port
   logic [31:0] mem_m [int];
   logic [31:0] exp_ir [2];
   logic [31:0] exp_dr [2];
   int          last_g [2];
   int          n_checks = 0;
   int          n_fail   = 0;

   typedef struct {
      int          inst;
      int          port;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   function automatic int ws(input int inst);
      return (inst == 0) ? 0 : 3;
   endfunction

   function automatic int key_of(input int inst, input logic [31:0] a);
      return inst * 4096 + int'(a[13:2]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait for the next completion on an instance and check it against the model
   task automatic complete(input int inst, input int port, output logic [31:0] got);
      int  n = 0;
      bit  seen = 0;
      int  k;
      while (!seen) begin
         @(negedge clk);
         if (iready[inst] || dready[inst]) begin
            seen = 1;
         end else begin
            chk("ibus_rdata_hold", irdata[inst], exp_ir[inst]);
            chk("dbus_rdata_hold", drdata[inst], exp_dr[inst]);
            n++;
            if (n > 40) begin
               n_checks++;
               n_fail++;
               $display("FAIL ready_timeout: inst %0d got no ready, required one within %0d cycles", inst, 2 + ws(inst));
               got = 'x;
               return;
            end
         end
      end
      chk("latency", 32'(n), 32'(2 + ws(inst)));
      chk("ibus_ready", {31'd0, iready[inst]}, {31'd0, port == PI});
      chk("dbus_ready", {31'd0, dready[inst]}, {31'd0, port == PD});
      if (port == PI) begin
         k = key_of(inst, iaddr[inst]);
         exp_ir[inst] = mem_m.exists(k) ? mem_m[k] : 32'h0;
         got = irdata[inst];
      end else if (!drw[inst]) begin
         k = key_of(inst, daddr[inst]);
         exp_dr[inst] = mem_m.exists(k) ? mem_m[k] : 32'h0;
         got = drdata[inst];
      end else begin
         mem_m[key_of(inst, daddr[inst])] = dwdata[inst];
         got = drdata[inst];
      end
      chk("ibus_rdata", irdata[inst], exp_ir[inst]);
      chk("dbus_rdata", drdata[inst], exp_dr[inst]);
      last_g[inst] = port;
      $display("txn inst=%0d port=%s rw=%0d ia=%h da=%h latency=%0d rdata=%h", inst,
               (port == PI) ? "I" : "D", (port == PD) ? drw[inst] : 1'b0,
               iaddr[inst], daddr[inst], n, got);
   endtask

   // Issue one or two requests at an IDLE cycle and retire them in the expected grant order
   task automatic do_pair(input int inst, input bit ui, input bit ud, input logic [31:0] ia,
                          input logic rw, input logic [31:0] da, input logic [31:0] dw,
                          output logic [31:0] got);
      int first;
      iaddr[inst] = ia; daddr[inst] = da; drw[inst] = rw; dwdata[inst] = dw;
      ireq[inst] = ui;  dreq[inst] = ud;
      if (ui && ud) first = (last_g[inst] == PD) ? PI : PD;
      else          first = ui ? PI : PD;
      complete(inst, first, got);
      @(posedge clk); #1;
      if (first == PI) ireq[inst] = 1'b0; else dreq[inst] = 1'b0;
      if (ui && ud) begin
         complete(inst, 1 - first, got);
         @(posedge clk); #1;
         if (first == PI) dreq[inst] = 1'b0; else ireq[inst] = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [10];
      logic [31:0] got;
      logic [31:0] a;
      int          exp_port;

      vecs[0] = '{0, PD, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[1] = '{0, PD, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
      vecs[2] = '{0, PD, 1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      vecs[3] = '{0, PD, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
      vecs[4] = '{0, PI, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
      vecs[5] = '{1, PD, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000};
      vecs[6] = '{1, PI, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678};
      vecs[7] = '{1, PD, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0000};
      vecs[8] = '{1, PD, 1'b0, 32'hFFFF_0008, 32'h0,         32'hCAFE_F00D};
      vecs[9] = '{0, PI, 1'b0, 32'h1000_4000, 32'h0,         32'hA5A5_A5A5};

      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; ireq[i] = 1'b0; dreq[i] = 1'b0; drw[i] = 1'b0;
         iaddr[i] = '0; daddr[i] = '0; dwdata[i] = '0;
         exp_ir[i] = '0; exp_dr[i] = '0; last_g[i] = PD;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_ibus_ready", {31'd0, iready[i]}, 32'd0);
         chk("reset_dbus_ready", {31'd0, dready[i]}, 32'd0);
         chk("reset_ibus_rdata", irdata[i], 32'd0);
         chk("reset_dbus_rdata", drdata[i], 32'd0);
         rst[i] = 1'b0;
      end
      @(posedge clk); #1;

      // Directed vectors: write/read, alias and low-bit-ignore cases on both wait-state settings
      for (int i = 0; i < 10; i++) begin
         do_pair(vecs[i].inst, vecs[i].port == PI, vecs[i].port == PD,
                 vecs[i].addr, vecs[i].rw, vecs[i].addr, vecs[i].wdata, got);
         chk("vector_rdata", got, vecs[i].exp);
      end

      // Both ports request in the same cycle: round-robin order from history
      do_pair(1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0008, 32'h0, got);
      // Dbus read of 0x8 while an ibus read waits behind it
      do_pair(0, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0, 32'h0, got);
      do_pair(0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0008, 32'h0, got);

      // Reset during WAIT of a dbus read: no ready, outputs cleared, then normal ibus latency
      daddr[1] = 32'h0000_0008; drw[1] = 1'b0; dreq[1] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("pre_reset_no_dbus_ready", {31'd0, dready[1]}, 32'd0);
      end
      rst[1] = 1'b1;
      #2;
      chk("midreset_dbus_ready", {31'd0, dready[1]}, 32'd0);
      chk("midreset_ibus_rdata", irdata[1], 32'd0);
      chk("midreset_dbus_rdata", drdata[1], 32'd0);
      @(posedge clk); #1;
      dreq[1] = 1'b0;
      rst[1] = 1'b0;
      exp_ir[1] = '0; exp_dr[1] = '0; last_g[1] = PD;
      do_pair(1, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 32'h0, 32'h0, got);
      chk("post_reset_ibus_rdata", got, 32'h1234_5678);

      // Both held continuously for 8 transactions: grants must alternate
      for (int inst = 0; inst < 2; inst++) begin
         iaddr[inst] = 32'h0000_0004; daddr[inst] = 32'h0000_0008; drw[inst] = 1'b0;
         ireq[inst] = 1'b1; dreq[inst] = 1'b1;
         exp_port = (last_g[inst] == PD) ? PI : PD;
         for (int t = 0; t < 8; t++) begin
            complete(inst, exp_port, got);
            @(posedge clk); #1;
            exp_port = 1 - exp_port;
         end
         ireq[inst] = 1'b0; dreq[inst] = 1'b0;
      end

      // Fill a small pool of word indices so every random read has a known value
      for (int inst = 0; inst < 2; inst++) begin
         for (int j = 0; j < 8; j++) begin
            a = $urandom;
            a[13:2] = 12'(j * 3);
            do_pair(inst, 1'b0, 1'b1, 32'h0, 1'b1, a, $urandom, got);
         end
      end

      // Randomized traffic on aliased pool addresses, single or simultaneous requests
      for (int r = 0; r < 60; r++) begin
         int          inst;
         bit          ui, ud;
         logic [31:0] ia, da;
         inst = int'($urandom_range(0, 1));
         ui = 1'($urandom_range(0, 1));
         ud = 1'($urandom_range(0, 1));
         if (!ui && !ud) ui = 1'b1;
         ia = $urandom; ia[13:2] = 12'($urandom_range(0, 7) * 3);
         da = $urandom; da[13:2] = 12'($urandom_range(0, 7) * 3);
         do_pair(inst, ui, ud, ia, 1'($urandom_range(0, 1)), da, $urandom, got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
